// File: rtl/text_overlay_pkg.sv
// text_overlay_pkg: shared types and constants for the text overlay engine.
// Field attributes, scale codes, write-select codes, glyph and colour constants.
package text_overlay_pkg;

  typedef enum logic [1:0] {
    SCALE_1X  = 2'd0,
    SCALE_2X  = 2'd1,
    SCALE_4X  = 2'd2,
    SCALE_4XB = 2'd3
  } scale_e;

  typedef struct packed {
    logic [9:0]  x0;
    logic [9:0]  y0;
    logic [11:0] colour;
    scale_e      scale;
    logic [4:0]  len;
    logic        blink;
  } attr_t;

  localparam logic [1:0] SEL_CHAR = 2'd0;
  localparam logic [1:0] SEL_POS  = 2'd1;
  localparam logic [1:0] SEL_ATTR = 2'd2;
  localparam logic [1:0] SEL_RSVD = 2'd3;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;

  localparam logic [11:0] COLOUR_BLACK = 12'h000;

endpackage

// File: rtl/text_overlay_if.sv
// text_overlay_if: pixel stream, config write port and overlay result.
// master drives pixels/config, slave (the engine) returns text_on/text_RGB.
interface text_overlay_if
  import text_overlay_pkg::*;
#(
  parameter int NUM_FIELDS = 9,
  parameter int MAX_CHARS  = 16
);
  localparam int FW  = $clog2(NUM_FIELDS);
  localparam int CIW = $clog2(MAX_CHARS);

  logic [9:0]     pixel_x;
  logic [9:0]     pixel_y;
  logic           frame_tick;
  logic           cfg_we;
  logic [FW-1:0]  cfg_field;
  logic [1:0]     cfg_sel;
  logic [CIW-1:0] cfg_index;
  logic [19:0]    cfg_data;
  logic           text_on;
  logic [11:0]    text_RGB;

  modport master (
    output pixel_x, pixel_y, frame_tick,
    output cfg_we, cfg_field, cfg_sel,
    output cfg_index, cfg_data,
    input  text_on, text_RGB
  );

  modport slave (
    input  pixel_x, pixel_y, frame_tick,
    input  cfg_we, cfg_field, cfg_sel,
    input  cfg_index, cfg_data,
    output text_on, text_RGB
  );

endinterface

// File: rtl/font_rom.sv
// font_rom: 8x16 glyph ROM, synchronous read, addr = {ASCII, row}.
// MSB of data is the leftmost glyph column.
module font_rom (
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  // registered glyph row lookup
  always_ff @(posedge clk) begin
    data <= {addr[10:4], addr[0]}
          ^ {addr[3:0], addr[3:0]}
          ^ 8'hA5;
  end

endmodule

// File: rtl/text_overlay_engine_hit.sv
// text_field_hit: per-field region test and glyph coordinate extraction.
// Sums are 11 bits wide so regions past x/y = 1023 clip instead of wrapping.
module text_field_hit
  import text_overlay_pkg::*;
#(
  parameter int MAX_CHARS = 16,
  localparam int CIW = $clog2(MAX_CHARS)
) (
  input  logic [9:0]     i_px,
  input  logic [9:0]     i_py,
  input  attr_t          i_attr,
  output logic           o_hit,
  output logic [CIW-1:0] o_idx,
  output logic [3:0]     o_row,
  output logic [2:0]     o_bit
);

  logic [1:0]  w_s;
  logic [4:0]  w_len;
  logic [10:0] w_wid;
  logic [10:0] w_hgt;
  logic [10:0] w_xend;
  logic [10:0] w_yend;
  logic [9:0]  w_dx;
  logic [9:0]  w_dy;
  logic [9:0]  w_dxs;
  logic [9:0]  w_dys;

  // region bounds and scaled offsets inside the field
  always_comb begin
    w_s    = (i_attr.scale == SCALE_4XB) ?
             2'd2 : 2'(i_attr.scale);
    w_len  = (i_attr.len > 5'(MAX_CHARS)) ?
             5'(MAX_CHARS) : i_attr.len;
    w_wid  = 11'({w_len, 3'b000}) << w_s;
    w_hgt  = 11'(GLYPH_H) << w_s;
    w_xend = {1'b0, i_attr.x0} + w_wid;
    w_yend = {1'b0, i_attr.y0} + w_hgt;
    w_dx   = i_px - i_attr.x0;
    w_dy   = i_py - i_attr.y0;
    w_dxs  = w_dx >> w_s;
    w_dys  = w_dy >> w_s;
    o_hit  = (w_len != 5'd0)
           && (i_px >= i_attr.x0)
           && ({1'b0, i_px} < w_xend)
           && (i_py >= i_attr.y0)
           && ({1'b0, i_py} < w_yend);
    o_idx  = CIW'(w_dxs >> 3);
    o_row  = 4'(w_dys);
    o_bit  = 3'(w_dxs);
  end

endmodule

// File: rtl/text_overlay_engine.sv
// text_overlay_engine: 3-stage runtime-programmable text overlay.
// Optional blink: define TEXT_OVERLAY_BLINK_EN.
module text_overlay_engine
  import text_overlay_pkg::*;
#(
  parameter int NUM_FIELDS   = 9,
  parameter int MAX_CHARS    = 16,
  parameter int BLINK_FRAMES = 30
) (
  input  logic           clk,
  input  logic           reset_n,
  text_overlay_if.slave  bus
);

  localparam int FW  = $clog2(NUM_FIELDS);
  localparam int CIW = $clog2(MAX_CHARS);

  logic [6:0] r_chars [NUM_FIELDS][MAX_CHARS];
  attr_t      r_shadow [NUM_FIELDS];
  attr_t      r_active [NUM_FIELDS];
  attr_t      w_shd_nxt [NUM_FIELDS];

  logic [NUM_FIELDS-1:0] w_hit;
  logic [NUM_FIELDS-1:0] w_hit_eff;
  logic [CIW-1:0]        w_idx [NUM_FIELDS];
  logic [3:0]            w_row [NUM_FIELDS];
  logic [2:0]            w_bit [NUM_FIELDS];

  logic        w_chr_we;
  logic        w_pos_we;
  logic        w_att_we;
  logic        w_sel_hit;
  logic [6:0]  w_sel_chr;
  logic [3:0]  w_sel_row;
  logic [2:0]  w_sel_bit;
  logic [11:0] w_sel_col;
  logic [7:0]  w_font;
  logic        w_pix;

  logic        r_s1_hit;
  logic [6:0]  r_s1_chr;
  logic [3:0]  r_s1_row;
  logic [2:0]  r_s1_bit;
  logic [11:0] r_s1_col;
  logic        r_s2_hit;
  logic [2:0]  r_s2_bit;
  logic [11:0] r_s2_col;

  assign w_chr_we = bus.cfg_we && (bus.cfg_sel == SEL_CHAR);
  assign w_pos_we = bus.cfg_we && (bus.cfg_sel == SEL_POS);
  assign w_att_we = bus.cfg_we && (bus.cfg_sel == SEL_ATTR);

  // shadow attributes with this cycle's write folded in
  always_comb begin
    for (int f = 0; f < NUM_FIELDS; f++) begin
      w_shd_nxt[f] = r_shadow[f];
      if (bus.cfg_field == FW'(f)) begin
        unique case (1'b1)
          w_pos_we: begin
            w_shd_nxt[f].x0 = bus.cfg_data[9:0];
            w_shd_nxt[f].y0 = bus.cfg_data[19:10];
          end
          w_att_we: begin
            w_shd_nxt[f].colour = bus.cfg_data[11:0];
            w_shd_nxt[f].scale  =
              scale_e'(bus.cfg_data[13:12]);
            w_shd_nxt[f].len    = bus.cfg_data[18:14];
            w_shd_nxt[f].blink  = bus.cfg_data[19];
          end
          default: ;
        endcase
      end
    end
  end

  // shadow follows writes; active copies shadow at frame start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int f = 0; f < NUM_FIELDS; f++) begin
        r_shadow[f] <= '0;
        r_active[f] <= '0;
      end
    end else begin
      r_shadow <= w_shd_nxt;
      if (bus.frame_tick) r_active <= w_shd_nxt;
    end
  end

  // char buffer, written immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int f = 0; f < NUM_FIELDS; f++)
        for (int c = 0; c < MAX_CHARS; c++)
          r_chars[f][c] <= '0;
    end else if (w_chr_we) begin
      for (int f = 0; f < NUM_FIELDS; f++)
        for (int c = 0; c < MAX_CHARS; c++)
          if (bus.cfg_field == FW'(f) &&
              bus.cfg_index == CIW'(c))
            r_chars[f][c] <= bus.cfg_data[6:0];
    end
  end

  for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_hit
    text_field_hit #(.MAX_CHARS(MAX_CHARS)) u_hit (
      .i_px   (bus.pixel_x),
      .i_py   (bus.pixel_y),
      .i_attr (r_active[g]),
      .o_hit  (w_hit[g]),
      .o_idx  (w_idx[g]),
      .o_row  (w_row[g]),
      .o_bit  (w_bit[g])
    );
  end

`ifdef TEXT_OVERLAY_BLINK_EN
  localparam int BCW = $clog2(BLINK_FRAMES + 1);
  logic [BCW-1:0] r_blink_cnt;
  logic           r_phase;

  // frame counter toggles phase every BLINK_FRAMES ticks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (bus.frame_tick) begin
      if (r_blink_cnt == BCW'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // blinking fields vanish entirely in the off phase
  always_comb begin
    w_hit_eff = w_hit;
    for (int f = 0; f < NUM_FIELDS; f++)
      if (r_phase && r_active[f].blink)
        w_hit_eff[f] = 1'b0;
  end
`else
  assign w_hit_eff = w_hit;
`endif

  // lowest-index hitting field wins
  always_comb begin
    w_sel_hit = 1'b0;
    w_sel_chr = '0;
    w_sel_row = '0;
    w_sel_bit = '0;
    w_sel_col = COLOUR_BLACK;
    for (int f = NUM_FIELDS - 1; f >= 0; f--) begin
      if (w_hit_eff[f]) begin
        w_sel_hit = 1'b1;
        w_sel_chr = r_chars[f][w_idx[f]];
        w_sel_row = w_row[f];
        w_sel_bit = w_bit[f];
        w_sel_col = r_active[f].colour;
      end
    end
  end

  // stage 1: winning field glyph coordinates
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_hit <= 1'b0;
      r_s1_chr <= '0;
      r_s1_row <= '0;
      r_s1_bit <= '0;
      r_s1_col <= COLOUR_BLACK;
    end else begin
      r_s1_hit <= w_sel_hit;
      r_s1_chr <= w_sel_chr;
      r_s1_row <= w_sel_row;
      r_s1_bit <= w_sel_bit;
      r_s1_col <= w_sel_col;
    end
  end

  font_rom u_font (
    .clk  (clk),
    .addr ({r_s1_chr, r_s1_row}),
    .data (w_font)
  );

  // stage 2: delay hit/bit/colour alongside the ROM read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_hit <= 1'b0;
      r_s2_bit <= '0;
      r_s2_col <= COLOUR_BLACK;
    end else begin
      r_s2_hit <= r_s1_hit;
      r_s2_bit <= r_s1_bit;
      r_s2_col <= r_s1_col;
    end
  end

  assign w_pix = r_s2_hit & w_font[3'd7 - r_s2_bit];

  // stage 3: registered overlay output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.text_on  <= 1'b0;
      bus.text_RGB <= COLOUR_BLACK;
    end else begin
      bus.text_on  <= w_pix;
      bus.text_RGB <= w_pix ? r_s2_col : COLOUR_BLACK;
    end
  end

endmodule

// File: tb/tb_text_overlay_engine.sv
// tb_text_overlay_engine: directed + random stimulus against a
// behavioural overlay model; outputs checked 3 cycles after each pixel.
module tb_text_overlay_engine;

  localparam int NF = 9;
  localparam int MC = 16;
  localparam int BF = 30;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  text_overlay_if #(.NUM_FIELDS(NF), .MAX_CHARS(MC)) bus();

  text_overlay_engine #(
    .NUM_FIELDS(NF), .MAX_CHARS(MC), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int m_chr [NF][MC];
  int a_x[NF], a_y[NF], a_col[NF], a_sc[NF], a_len[NF], a_bl[NF];
  int s_x[NF], s_y[NF], s_col[NF], s_sc[NF], s_len[NF], s_bl[NF];
  int m_ticks;

  typedef struct {
    logic        on;
    logic [11:0] rgb;
    int          px;
    int          py;
  } exp_t;
  exp_t q[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int font(int a, int r);
    return ((a * 2 + r % 2) ^ (r * 17) ^ 165) & 255;
  endfunction

  function automatic int clamp(int v);
    return v < 0 ? 0 : (v > 1023 ? 1023 : v);
  endfunction

  function automatic exp_t predict(int px, int py);
    exp_t e;
    e.on = 1'b0; e.rgb = 12'h000; e.px = px; e.py = py;
    for (int f = 0; f < NF; f++) begin
      int s, len, cw, ch, c, r, b, w;
      s   = (a_sc[f] == 3) ? 2 : a_sc[f];
      len = (a_len[f] > MC) ? MC : a_len[f];
      cw  = 8 << s;
      ch  = 16 << s;
      if (len == 0) continue;
`ifdef TEXT_OVERLAY_BLINK_EN
      if (a_bl[f] == 1 && ((m_ticks / BF) % 2) == 1) continue;
`endif
      if (px >= a_x[f] && px < a_x[f] + len * cw &&
          py >= a_y[f] && py < a_y[f] + ch) begin
        c = (px - a_x[f]) / cw;
        r = ((py - a_y[f]) / (1 << s)) % 16;
        b = ((px - a_x[f]) / (1 << s)) % 8;
        w = font(m_chr[f][c], r);
        e.on  = ((w >> (7 - b)) & 1) == 1;
        e.rgb = e.on ? 12'(a_col[f]) : 12'h000;
        return e;
      end
    end
    return e;
  endfunction

  task automatic model_clear();
    for (int f = 0; f < NF; f++) begin
      for (int c = 0; c < MC; c++) m_chr[f][c] = 0;
      a_x[f] = 0; a_y[f] = 0; a_col[f] = 0;
      a_sc[f] = 0; a_len[f] = 0; a_bl[f] = 0;
      s_x[f] = 0; s_y[f] = 0; s_col[f] = 0;
      s_sc[f] = 0; s_len[f] = 0; s_bl[f] = 0;
    end
    m_ticks = 0;
    q.delete();
    repeat (3) q.push_back('{1'b0, 12'h000, -1, -1});
  endtask

  task automatic model_update(bit we, int fld, int sel, int idx,
                              logic [19:0] d, bit tick);
    if (we && fld < NF) begin
      case (sel)
        0: m_chr[fld][idx] = int'(d[6:0]);
        1: begin s_x[fld] = int'(d[9:0]); s_y[fld] = int'(d[19:10]); end
        2: begin
          s_col[fld] = int'(d[11:0]);  s_sc[fld] = int'(d[13:12]);
          s_len[fld] = int'(d[18:14]); s_bl[fld] = int'(d[19]);
        end
        default: ;
      endcase
    end
    if (tick) begin
      a_x = s_x; a_y = s_y; a_col = s_col;
      a_sc = s_sc; a_len = s_len; a_bl = s_bl;
      m_ticks++;
    end
  endtask

  // called at a negedge: check, drive one cycle, advance to next negedge
  task automatic step(int px, int py, bit tick, bit we,
                      int fld, int sel, int idx, logic [19:0] d);
    exp_t e;
    e = q.pop_front();
    check($sformatf("text_on@%0d,%0d", e.px, e.py), 32'(bus.text_on), 32'(e.on));
    check($sformatf("text_RGB@%0d,%0d", e.px, e.py), 32'(bus.text_RGB), 32'(e.rgb));
    bus.pixel_x    = 10'(px);
    bus.pixel_y    = 10'(py);
    bus.frame_tick = tick;
    bus.cfg_we     = we;
    bus.cfg_field  = 4'(fld);
    bus.cfg_sel    = 2'(sel);
    bus.cfg_index  = 4'(idx);
    bus.cfg_data   = d;
    q.push_back(predict(px, py));
    model_update(we, fld, sel, idx, d, tick);
    @(negedge clk);
  endtask

  task automatic pix(int px, int py);
    step(px, py, 1'b0, 1'b0, 0, 0, 0, 20'h0);
  endtask

  task automatic wr(int fld, int sel, int idx, logic [19:0] d);
    step(1023, 1023, 1'b0, 1'b1, fld, sel, idx, d);
  endtask

  task automatic tick();
    step(1023, 1023, 1'b1, 1'b0, 0, 0, 0, 20'h0);
  endtask

  function automatic logic [19:0] pos(int x, int y);
    return {10'(y), 10'(x)};
  endfunction

  function automatic logic [19:0] attr(int col, int sc, int len, int bl);
    return {1'(bl), 5'(len), 2'(sc), 12'(col)};
  endfunction

  task automatic scan(int y, int x0, int x1);
    for (int x = x0; x <= x1; x++) pix(x, y);
  endtask

  task automatic apply_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_text_on", 32'(bus.text_on), 32'h0);
    check("rst_text_RGB", 32'(bus.text_RGB), 32'h0);
    @(negedge clk);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.pixel_x = 10'd1023; bus.pixel_y = 10'd1023;
    bus.frame_tick = 1'b0; bus.cfg_we = 1'b0;
    bus.cfg_field = '0; bus.cfg_sel = '0;
    bus.cfg_index = '0; bus.cfg_data = '0;
    @(negedge clk);
    apply_reset();
    scan(8, 250, 260);

    // "HORA" at 4x, colour 2F2
    wr(0, 0, 0, 20'h48); wr(0, 0, 1, 20'h4F);
    wr(0, 0, 2, 20'h52); wr(0, 0, 3, 20'h41);
    wr(0, 1, 0, pos(256, 0));
    wr(0, 2, 0, attr(12'h2F2, 2, 4, 0));
    scan(8, 250, 270);
    tick();
    scan(8, 250, 390);
    scan(63, 380, 390);
    scan(64, 256, 266);

    // overlapping fields 0 and 1 at (100,100), 1x
    wr(1, 0, 0, 20'h42); wr(1, 0, 1, 20'h43);
    wr(1, 1, 0, pos(100, 100));
    wr(1, 2, 0, attr(12'h00F, 0, 2, 0));
    wr(0, 1, 0, pos(100, 100));
    wr(0, 2, 0, attr(12'hF00, 0, 2, 0));
    tick();
    for (int y = 100; y < 116; y++) scan(y, 98, 117);

    // position change held until frame_tick
    wr(2, 0, 0, 20'h5A); wr(2, 0, 1, 20'h39);
    wr(2, 1, 0, pos(50, 300));
    wr(2, 2, 0, attr(12'h0F0, 1, 2, 0));
    tick();
    scan(305, 48, 84);
    wr(2, 1, 0, pos(300, 200));
    scan(305, 48, 84);
    scan(205, 296, 334);
    tick();
    scan(205, 296, 334);
    scan(305, 48, 84);

    // right-edge clip, no wrap to x = 0
    wr(3, 0, 0, 20'h4D);
    wr(3, 1, 0, pos(1000, 500));
    wr(3, 2, 0, attr(12'hABC, 2, 4, 0));
    tick();
    scan(510, 990, 1023);
    scan(510, 0, 40);

    // saturated length, scale code 3
    wr(5, 1, 0, pos(0, 700));
    wr(5, 2, 0, attr(12'h5A5, 3, 31, 0));
    tick();
    scan(730, 500, 530);
    scan(730, 0, 20);

    // blink field across many frames
    wr(4, 0, 0, 20'h57);
    wr(4, 1, 0, pos(600, 600));
    wr(4, 2, 0, attr(12'hFFF, 0, 1, 1));
    for (int fr = 0; fr < 65; fr++) begin
      tick();
      scan(604, 600, 607);
    end

    // randomized config and pixel traffic
    for (int r = 0; r < 25; r++) begin
      repeat (6)
        wr($urandom_range(0, 15), $urandom_range(0, 3),
           $urandom_range(0, 15), 20'($urandom));
      tick();
      repeat (100) begin
        int f;
        f = $urandom_range(0, NF - 1);
        step(clamp(a_x[f] + $urandom_range(0, 300) - 10),
             clamp(a_y[f] + $urandom_range(0, 80) - 5),
             $urandom_range(0, 49) == 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 15), $urandom_range(0, 3),
             $urandom_range(0, 15), 20'($urandom));
      end
    end

    // reset in the middle of a lit line
    wr(0, 0, 0, 20'h48);
    wr(0, 1, 0, pos(256, 0));
    wr(0, 2, 0, attr(12'h2F2, 2, 4, 0));
    tick();
    n = 0;
    while (!q[0].on && n < 200) begin
      pix(256 + n, 8);
      n++;
    end
    check("lit_before_reset", 32'(q[0].on), 32'h1);
    apply_reset();
    scan(8, 250, 300);
    tick();
    scan(8, 250, 300);
    wr(0, 2, 0, attr(12'h2F2, 2, 4, 0));
    tick();
    scan(8, 250, 300);
    repeat (3) pix(1023, 1023);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
